// File: rtl/ula_seq_if.sv
// Operand/result handshake bundle for ula_seq: A/B/COND in with valid/ready,
// product-capable result out with valid/ready.
interface ula_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       COND;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] OUT_HI;
  logic             CARRY;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (
    output A, B, COND, IN_VALID, OUT_READY,
    input  IN_READY, OUT, OUT_HI, CARRY, OUT_VALID
  );

  modport slave (
    input  A, B, COND, IN_VALID, OUT_READY,
    output IN_READY, OUT, OUT_HI, CARRY, OUT_VALID
  );
endinterface

// File: rtl/ula_seq.sv
// Registered ALU: single-cycle add/sub/compare/logic ops and a WIDTH-iteration
// shift-add multiplier, one operation in flight, valid/ready on both sides.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input logic     CLK,
  input logic     RST,
  ula_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                 in_ready;
  logic                 accept;
  logic                 vld_p1;
  logic [WIDTH-1:0]     out_p1;
  logic [WIDTH-1:0]     out_hi_p1;
  logic                 carry_p1;
  logic [2*WIDTH-1:0]   mcand_p0;
  logic [WIDTH-1:0]     mplier_p0;
  logic [2*WIDTH-1:0]   acc_p0;
  logic [CNT_W-1:0]     cnt_p0;

  // Returns {carry, result} for every non-multiply opcode.
  function automatic logic [WIDTH:0] alu_op(input logic [2:0] cond,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (cond)
      3'b000: r = {1'b0, a} + {1'b0, b};
      3'b001: r = {1'b0, a} - {1'b0, b};
      3'b010: r = {{WIDTH{1'b0}}, (a == b)};
      3'b011: r = {{WIDTH{1'b0}}, ((a == WIDTH'(1)) | (b == WIDTH'(1)))};
      3'b100: r = {1'b0, a & b};
      3'b101: r = {1'b0, a | b};
      3'b110: r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready = (state == IDLE) & ~RST;
  assign accept   = bus.IN_VALID & in_ready;
  assign vld_p1   = (state == DONE);

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = vld_p1;
  assign bus.OUT       = out_p1;
  assign bus.OUT_HI    = out_hi_p1;
  assign bus.CARRY     = carry_p1;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.COND == 3'b111) ? MUL : DONE;
      MUL:  if (cnt_p0 == CNT_LAST) state_nxt = DONE;
      DONE: if (bus.OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture and multiply iterations
  always_ff @(posedge CLK) begin
    if (state == IDLE && accept) begin
      mcand_p0  <= {{WIDTH{1'b0}}, bus.A};
      mplier_p0 <= bus.B;
    end else if (state == MUL && cnt_p0 != CNT_LAST) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // Stage p1: result registers, held through backpressure; cleared on reset
  // because a discarded op must not leave a stale result visible.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_p1    <= '0;
      out_hi_p1 <= '0;
      carry_p1  <= 1'b0;
      acc_p0    <= '0;
      cnt_p0    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.COND == 3'b111) begin
              acc_p0 <= '0;
              cnt_p0 <= '0;
            end else begin
              {carry_p1, out_p1} <= alu_op(bus.COND, bus.A, bus.B);
              out_hi_p1          <= '0;
            end
          end
        end
        MUL: begin
          if (cnt_p0 == CNT_LAST) begin
            out_p1    <= acc_p0[WIDTH-1:0];
            out_hi_p1 <= acc_p0[2*WIDTH-1:WIDTH];
            carry_p1  <= |acc_p0[2*WIDTH-1:WIDTH];
          end else begin
            acc_p0 <= acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
            cnt_p0 <= cnt_p0 + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: 8-bit and 16-bit instances sharing clock and reset.
module tb_ula_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat;

  always #5 CLK = ~CLK;

  ula_seq_if #(.WIDTH(8))  u8 ();
  ula_seq_if #(.WIDTH(16)) u16 ();

  ula_seq #(.WIDTH(8))  dut8  (.CLK(CLK), .RST(RST), .bus(u8.slave));
  ula_seq #(.WIDTH(16)) dut16 (.CLK(CLK), .RST(RST), .bus(u16.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presents an op for one edge, then counts edges until OUT_VALID.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                        output int l);
    u8.A = a; u8.B = b; u8.COND = c; u8.IN_VALID = 1'b1;
    chk("in_ready_before_accept", 64'(u8.IN_READY), 64'd1);
    step();
    u8.IN_VALID = 1'b0;
    u8.A = 8'hAA; u8.B = 8'h55; u8.COND = 3'b110;
    l = 0;
    while (!u8.OUT_VALID && l < 100) begin
      step();
      l++;
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                         output int l);
    u16.A = a; u16.B = b; u16.COND = c; u16.IN_VALID = 1'b1;
    step();
    u16.IN_VALID = 1'b0;
    u16.A = 16'h1234; u16.B = 16'h4321;
    l = 0;
    while (!u16.OUT_VALID && l < 100) begin
      step();
      l++;
    end
  endtask

  task automatic release8(input string tag);
    u8.OUT_READY = 1'b1;
    step();
    u8.OUT_READY = 1'b0;
    chk({tag, "_valid_drop"}, 64'(u8.OUT_VALID), 64'd0);
    chk({tag, "_in_ready"}, 64'(u8.IN_READY), 64'd1);
  endtask

  task automatic res8(input string tag, input logic [7:0] o, input logic [7:0] hi, input logic c);
    chk({tag, "_out"}, 64'(u8.OUT), 64'(o));
    chk({tag, "_out_hi"}, 64'(u8.OUT_HI), 64'(hi));
    chk({tag, "_carry"}, 64'(u8.CARRY), 64'(c));
    chk({tag, "_valid"}, 64'(u8.OUT_VALID), 64'd1);
  endtask

  initial begin
    u8.A = '0; u8.B = '0; u8.COND = '0; u8.IN_VALID = 1'b0; u8.OUT_READY = 1'b0;
    u16.A = '0; u16.B = '0; u16.COND = '0; u16.IN_VALID = 1'b0; u16.OUT_READY = 1'b0;
    RST = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(u8.OUT_VALID), 64'd0);
    chk("rst_out", 64'(u8.OUT), 64'd0);
    chk("rst_out_hi", 64'(u8.OUT_HI), 64'd0);
    chk("rst_carry", 64'(u8.CARRY), 64'd0);
    chk("rst_in_ready_low", 64'(u8.IN_READY), 64'd0);
    RST = 1'b0;
    #1;
    chk("rst_in_ready_high", 64'(u8.IN_READY), 64'd1);

    // Single-cycle ops: result visible right after the accept edge.
    issue8(8'h06, 8'h60, 3'b000, lat);
    chk("add_lat", 64'(lat), 64'd0);
    res8("add_basic", 8'h66, 8'h00, 1'b0);
    release8("add_basic");

    issue8(8'hF0, 8'h20, 3'b000, lat);
    res8("add_wrap", 8'h10, 8'h00, 1'b1);
    release8("add_wrap");

    issue8(8'h03, 8'h05, 3'b001, lat);
    res8("sub_borrow", 8'hFE, 8'h00, 1'b1);
    release8("sub_borrow");

    issue8(8'h09, 8'h04, 3'b001, lat);
    res8("sub_plain", 8'h05, 8'h00, 1'b0);
    release8("sub_plain");

    issue8(8'h5A, 8'h5A, 3'b010, lat);
    res8("eq_true", 8'h01, 8'h00, 1'b0);
    release8("eq_true");

    issue8(8'h5A, 8'h5B, 3'b010, lat);
    res8("eq_false", 8'h00, 8'h00, 1'b0);
    release8("eq_false");

    issue8(8'h01, 8'h80, 3'b011, lat);
    res8("one_true", 8'h01, 8'h00, 1'b0);
    release8("one_true");

    issue8(8'h03, 8'h80, 3'b011, lat);
    res8("one_false", 8'h00, 8'h00, 1'b0);
    release8("one_false");

    issue8(8'hCC, 8'hAA, 3'b100, lat);
    res8("and", 8'h88, 8'h00, 1'b0);
    release8("and");

    issue8(8'hCC, 8'hAA, 3'b101, lat);
    res8("or", 8'hEE, 8'h00, 1'b0);
    release8("or");

    issue8(8'hCC, 8'hAA, 3'b110, lat);
    res8("xor", 8'h66, 8'h00, 1'b0);
    release8("xor");

    // Multiply: valid WIDTH+1 edges after accept.
    issue8(8'hFF, 8'hFF, 3'b111, lat);
    chk("mul_ff_lat", 64'(lat), 64'd9);
    res8("mul_ff", 8'h01, 8'hFE, 1'b1);
    release8("mul_ff");

    issue8(8'h0C, 8'h0A, 3'b111, lat);
    chk("mul_small_lat", 64'(lat), 64'd9);
    res8("mul_small", 8'h78, 8'h00, 1'b0);

    // Backpressure: result held, new request ignored for 5 cycles.
    u8.A = 8'h11; u8.B = 8'h22; u8.COND = 3'b000; u8.IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      res8("bp_hold", 8'h78, 8'h00, 1'b0);
      chk("bp_in_ready", 64'(u8.IN_READY), 64'd0);
    end
    u8.IN_VALID = 1'b0;
    release8("bp");
    step();
    chk("bp_no_stray_accept", 64'(u8.OUT_VALID), 64'd0);

    // Reset in the middle of a multiply discards it.
    issue8(8'h02, 8'h03, 3'b001, lat);
    release8("pre_rst_sub");
    u8.A = 8'hFF; u8.B = 8'hFF; u8.COND = 3'b111; u8.IN_VALID = 1'b1;
    step();
    u8.IN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) step();
    RST = 1'b1;
    step();
    chk("midmul_rst_out", 64'(u8.OUT), 64'd0);
    chk("midmul_rst_out_hi", 64'(u8.OUT_HI), 64'd0);
    chk("midmul_rst_carry", 64'(u8.CARRY), 64'd0);
    chk("midmul_rst_valid", 64'(u8.OUT_VALID), 64'd0);
    chk("midmul_rst_in_ready", 64'(u8.IN_READY), 64'd0);
    RST = 1'b0;
    #1;
    chk("after_rst_in_ready", 64'(u8.IN_READY), 64'd1);
    issue8(8'h01, 8'h01, 3'b000, lat);
    chk("after_rst_lat", 64'(lat), 64'd0);
    res8("after_rst_add", 8'h02, 8'h00, 1'b0);
    release8("after_rst_add");
    for (int i = 0; i < 12; i++) begin
      step();
      chk("after_rst_quiet", 64'(u8.OUT_VALID), 64'd0);
    end

    // 16-bit instance.
    issue16(16'hFFFF, 16'h0001, 3'b000, lat);
    chk("w16_add_out", 64'(u16.OUT), 64'h0000);
    chk("w16_add_carry", 64'(u16.CARRY), 64'd1);
    chk("w16_add_out_hi", 64'(u16.OUT_HI), 64'h0000);
    u16.OUT_READY = 1'b1;
    step();
    u16.OUT_READY = 1'b0;
    chk("w16_add_drop", 64'(u16.OUT_VALID), 64'd0);

    issue16(16'hFFFF, 16'h0002, 3'b111, lat);
    chk("w16_mul_lat", 64'(lat), 64'd17);
    chk("w16_mul_out", 64'(u16.OUT), 64'hFFFE);
    chk("w16_mul_out_hi", 64'(u16.OUT_HI), 64'h0001);
    chk("w16_mul_carry", 64'(u16.CARRY), 64'd1);
    u16.OUT_READY = 1'b1;
    step();
    u16.OUT_READY = 1'b0;
    chk("w16_mul_drop", 64'(u16.OUT_VALID), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, registered successor to the team's 8-bit combinational ULA. Adds a WIDTH parameter, a 3-bit operation code with logic ops and a multi-cycle shift-add multiplier, and valid/ready handshakes on input and output. Sits between an operand source (register file or sequencer) and a result sink. Accepts one operation at a time.

Parameters:
WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  synchronous reset, active-high.
A  in  WIDTH  operand A, captured on accept.
B  in  WIDTH  operand B, captured on accept.
COND  in  3  opcode, captured on accept.
IN_VALID  in  1  source presents A/B/COND.
IN_READY  out  1  block can accept an operation.
OUT  out  WIDTH  result, or low half of the product.
OUT_HI  out  WIDTH  high half of the product; 0 for every other op.
CARRY  out  1  carry, borrow or overflow flag (see below).
OUT_VALID  out  1  result is valid.
OUT_READY  in  1  sink takes the result.

Behaviour:
- States: IDLE, MUL, DONE. Accept when IN_VALID & IN_READY. IN_READY = (state==IDLE) & ~RST, combinational.
- On accept, A, B and COND are registered. Later changes on the input ports have no effect.
- Ops:
  - 000 add: {CARRY,OUT} = A+B, computed at WIDTH+1 bits.
  - 001 sub: OUT = A-B mod 2^WIDTH; CARRY = 1 iff A<B (borrow).
  - 010 eq: OUT = (A==B) zero-extended; CARRY = 0.
  - 011 one: OUT = ((A==1)|(B==1)) zero-extended; CARRY = 0.
  - 100 and, 101 or, 110 xor: bitwise; CARRY = 0.
  - 111 mul: {OUT_HI,OUT} = A*B, unsigned; CARRY = (OUT_HI != 0).
- Single-cycle ops (000-110): IDLE -> DONE on accept. OUT_VALID rises on the next edge, so latency is 1 cycle.
- mul: IDLE -> MUL on accept.
  - Iteration counter starts at 0. Each cycle: if multiplier bit is 1, add the shifted multiplicand into the 2*WIDTH accumulator; then shift.
  - After exactly WIDTH iterations, MUL -> DONE. OUT_VALID asserts WIDTH+1 cycles after the accept edge.
- DONE:
  - OUT_VALID = 1. OUT, OUT_HI and CARRY hold stable until OUT_VALID & OUT_READY.
  - On that handshake: DONE -> IDLE. OUT_VALID drops on the next edge; OUT, OUT_HI and CARRY keep their last values.
  - IN_READY stays 0 in DONE. There is no accept in the same cycle as the output handshake, so the next op can be accepted one cycle later at the earliest.
- IN_VALID in MUL or DONE is ignored; the source must hold it.
- Reset (RST=1 on an edge), from any state including mid-MUL or a pending DONE:
  - state = IDLE, OUT_VALID = 0, OUT = 0, OUT_HI = 0, CARRY = 0.
  - Accumulator and counter cleared. An in-flight op is discarded with no result.
  - IN_READY = 0 while RST is high; 1 in the first cycle RST is low.
- Wrap-around:
  - add/sub wrap modulo 2^WIDTH, with CARRY reporting the lost bit.
  - mul never loses bits: full 2*WIDTH result.
- OUT_VALID never toggles without a handshake or reset. Exactly one result per accepted op.

Test Plan:
1. WIDTH=8, A=0x06, B=0x60, COND=000 -> one cycle after accept: OUT=0x66, CARRY=0, OUT_HI=0x00, OUT_VALID=1.
2. WIDTH=8, add A=0xF0, B=0x20 -> OUT=0x10, CARRY=1. Sub A=0x03, B=0x05 -> OUT=0xFE, CARRY=1. Eq A=B=0x5A -> OUT=0x01. One A=0x01, B=0x80 -> OUT=0x01.
3. WIDTH=8, mul A=0xFF, B=0xFF -> OUT_VALID exactly 9 cycles after the accept edge: OUT_HI=0xFE, OUT=0x01, CARRY=1. Mul 0x0C*0x0A -> OUT=0x78, OUT_HI=0, CARRY=0.
4. Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID -> OUT/OUT_HI/CARRY unchanged, IN_READY=0, a new IN_VALID is ignored. OUT_READY=1 -> OUT_VALID=0 next cycle, IN_READY=1.
5. Reset mid-mul: RST=1 at iteration 4 of 0xFF*0xFF -> next edge: all outputs 0, OUT_VALID stays 0. After RST falls, add 1+1 -> OUT=0x02 with no stale product.
6. WIDTH=16, add 0xFFFF+0x0001 -> OUT=0x0000, CARRY=1. Mul 0xFFFF*0x0002 -> OUT_HI=0x0001, OUT=0xFFFE, OUT_VALID 17 cycles after accept.
